dmem_arbiter: RTL

Two-requester arbiter and sequencer for the 32-word data memory. It accepts load/store requests from the CPU port and a DMA/debug port with a valid/grant handshake. Each cycle it picks at most one winner, using round-robin or CPU-priority with starvation protection. It then drives the memory's `memwrite`/`memread`/`address`/`wdata` strobes for exactly one cycle and returns read data to the owning requester with a registered valid pulse.

---
 rtl/dmem_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and 3-stage sequencer for the data memory.
// Grants one of CPU/DMA per cycle, issues registered strobes, returns load data.
module dmem_arbiter #(
  parameter int DEPTH        = 32,
  parameter int CPU_PRIORITY = 0,
  parameter int MAX_WAIT     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        cpu_gnt,
  output logic        dma_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   we;
    logic   oor;
  } iss_t;

  localparam int          WW    = (MAX_WAIT < 1) ? 1
                                : $clog2(MAX_WAIT + 1);
  localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  owner_e          last;
  logic [WW-1:0]   wait_cnt;
  iss_t            iss;

  logic            req_c;
  logic            req_d;
  logic            starve;
  logic            cpu_win;
  logic            dma_win;
  logic            acc;
  logic            sel_we;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_wdata;
  logic            sel_inr;
  logic            rsp;
  logic            rsp_c;
  logic            rsp_d;
  logic [31:0]     rsp_data;

  // Requests are ignored while reset is held.
  assign req_c  = cpu_req & rst_n;
  assign req_d  = dma_req & rst_n;
  assign starve = (CPU_PRIORITY != 0)
                & (wait_cnt == WMAX);

  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    unique case (1'b1)
      req_c && req_d: begin
        if (CPU_PRIORITY != 0)
          dma_win = starve;
        else
          dma_win = (last == OWN_CPU);
        cpu_win = !dma_win;
      end
      req_c && !req_d: cpu_win = 1'b1;
      !req_c && req_d: dma_win = 1'b1;
      default: begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
      end
    endcase
  end

  assign cpu_gnt = cpu_win;
  assign dma_gnt = dma_win;
  assign acc     = cpu_win | dma_win;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    unique case (1'b1)
      cpu_win: begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
      end
      dma_win: begin
        sel_we    = dma_we;
        sel_addr  = dma_addr;
        sel_wdata = dma_wdata;
      end
      default: begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
      end
    endcase
  end

  assign sel_inr = (sel_addr < LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= OWN_DMA;
    end else if (acc) begin
      last <= dma_win ? OWN_DMA : OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (dma_req && !dma_win) begin
      if (wait_cnt != WMAX)
        wait_cnt <= wait_cnt + WW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // ISSUE stage: out-of-range accesses travel without touching memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss       <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      iss.valid <= acc;
      iss.owner <= dma_win ? OWN_DMA : OWN_CPU;
      iss.we    <= acc & sel_we;
      iss.oor   <= acc & !sel_inr;
      mem_write <= acc & sel_inr & sel_we;
      mem_read  <= acc & sel_inr & !sel_we;
      if (acc && sel_inr)
        mem_addr <= {sel_addr[31:2], 2'b00};
      else
        mem_addr <= '0;
      if (acc && sel_inr && sel_we)
        mem_wdata <= sel_wdata;
      else
        mem_wdata <= '0;
    end
  end

  // RESPOND stage: loads and any out-of-range access answer.
  assign rsp      = iss.valid & (!iss.we | iss.oor);
  assign rsp_c    = rsp & (iss.owner == OWN_CPU);
  assign rsp_d    = rsp & (iss.owner == OWN_DMA);
  assign rsp_data = iss.oor ? 32'h0 : mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
    end else begin
      cpu_rvalid <= rsp_c;
      cpu_err    <= rsp_c & iss.oor;
      cpu_rdata  <= rsp_c ? rsp_data : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
      dma_err    <= 1'b0;
    end else begin
      dma_rvalid <= rsp_d;
      dma_err    <= rsp_d & iss.oor;
      dma_rdata  <= rsp_d ? rsp_data : 32'h0;
    end
  end

endmodule
